// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter and its line synchroniser.
// Contents: FSM state encoding, keyboard command bytes, device reply codes,
// and the odd-parity helper used when a command byte is accepted.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_WAIT_EDGE = 3'd3,
    ST_FRAME     = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

  localparam logic [7:0] PS2_SCAN_ACK    = 8'hFA;
  localparam logic [7:0] PS2_SCAN_RESEND = 8'hFE;

  // PS/2 frames use odd parity: the parity bit makes the count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a controller and the PS/2 host transmitter.
//   tx_data/tx_valid : command byte and request (controller -> transmitter)
//   tx_ready         : transmitter idle, request will be accepted
//   done             : one-cycle end-of-transfer pulse
//   ack_ok/error     : transfer outcome, held until the next accept
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       done;
  logic       ack_ok;
  logic       error;

  modport master (output tx_data, tx_valid, input tx_ready, done, ack_ok, error);
  modport slave  (input tx_data, tx_valid, output tx_ready, done, ack_ok, error);
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the raw PS2_CLK / PS2_DAT pads plus a one-cycle
// pulse on each synchronised 1->0 clock transition. Shared with the receiver.
//   clk_in/data_in : asynchronous pad inputs
//   clk_s/data_s   : synchronised line levels (reset to idle-high)
//   fall           : one-cycle pulse on a synchronised clock falling edge
module ps2_line_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_s,
  output logic data_s,
  output logic fall
);

  logic [1:0] clk_ff_r;
  logic [1:0] data_ff_r;
  logic       clk_prev_r;

  // Synchroniser chains and previous clock level for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_ff_r   <= 2'b11;
      data_ff_r  <= 2'b11;
      clk_prev_r <= 1'b1;
    end else begin
      clk_ff_r   <= {clk_ff_r[0], clk_in};
      data_ff_r  <= {data_ff_r[0], data_in};
      clk_prev_r <= clk_ff_r[1];
    end
  end

  assign clk_s  = clk_ff_r[1];
  assign data_s = data_ff_r[1];
  assign fall   = clk_prev_r & ~clk_ff_r[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard
// using the inhibit / request-to-send / device-clocked frame and checks the
// device ACK bit. Lines are open-drain, driven through pad enables.
//   clk, reset_n            : system clock, asynchronous active-low reset
//   bus (slave)             : command handshake and transfer result
//   rx_inhibit              : mutes the neighbouring receiver while busy
//   ps2_clk_in/ps2_data_in  : raw pads
//   ps2_clk_oe/ps2_data_oe  : 1 pulls the line low, 0 releases it
// Optional feature macro PS2_TX_RETRY_EN: on NACK or timeout, retry up to
// MAX_RETRY extra times before reporting the error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int INHIBIT_CYC = 6000,
  parameter int START_TO    = 750_000,
  parameter int PKT_TO      = 100_000,
  parameter int MAX_RETRY   = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  ps2_host_tx_if.slave bus,
  output logic         rx_inhibit,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  logic clk_s, data_s, fall_s;

  ps2_line_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_in  (ps2_clk_in),
    .data_in (ps2_data_in),
    .clk_s   (clk_s),
    .data_s  (data_s),
    .fall    (fall_s)
  );

  state_t      state_r, state_n;
  logic [31:0] cnt_r, cnt_n;      // inhibit length, then start / packet timer
  logic [3:0]  k_r, k_n;          // device clock falls seen in this frame
  logic [7:0]  byte_r, byte_n;
  logic        par_r, par_n;
  logic        clk_oe_r, clk_oe_n;
  logic        data_oe_r, data_oe_n;
  logic        done_r, done_n;
  logic        ack_r, ack_n;
  logic        err_r, err_n;
  logic        fail_s, nack_s, retry_s;
`ifdef PS2_TX_RETRY_EN
  localparam logic [7:0] RETRY_LIM = 8'(MAX_RETRY);
  logic [7:0]  retry_r, retry_n;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    k_n       = k_r;
    byte_n    = byte_r;
    par_n     = par_r;
    clk_oe_n  = clk_oe_r;
    data_oe_n = data_oe_r;
    done_n    = 1'b0;
    ack_n     = ack_r;
    err_n     = err_r;
    fail_s    = 1'b0;
    nack_s    = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_n   = retry_r;
`endif

    case (state_r)
      ST_IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        // Accepting even mid device-frame is safe: the device resends later.
        if (bus.tx_valid) begin
          byte_n   = bus.tx_data;
          par_n    = odd_parity(bus.tx_data);
          ack_n    = 1'b0;
          err_n    = 1'b0;
          cnt_n    = 32'd0;
          clk_oe_n = 1'b1;
          state_n  = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_n  = 8'd0;
`endif
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        cnt_n = cnt_r + 32'd1;
        // Start bit goes out on the final inhibit cycle, before clock release.
        if (cnt_r >= 32'(INHIBIT_CYC - 2)) data_oe_n = 1'b1;
        else                              data_oe_n = 1'b0;
        if (cnt_r == 32'(INHIBIT_CYC - 1)) begin
          clk_oe_n = 1'b0;
          state_n  = ST_REQ;
        end else begin
          clk_oe_n = 1'b1;
        end
      end
      ST_REQ: begin
        cnt_n   = 32'd0;
        state_n = ST_WAIT_EDGE;
      end
      ST_WAIT_EDGE: begin
        if (fall_s) begin
          k_n       = 4'd1;
          data_oe_n = ~byte_r[0];
          cnt_n     = 32'd0;
          state_n   = ST_FRAME;
        end else if (cnt_r == 32'(START_TO - 1)) begin
          fail_s = 1'b1;
        end else begin
          cnt_n = cnt_r + 32'd1;
        end
      end
      ST_FRAME: begin
        cnt_n = cnt_r + 32'd1;
        if (fall_s) begin
          k_n = k_r + 4'd1;
          // k_r is the count before this fall; the new fall is k_r + 1.
          case (k_r)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: data_oe_n = ~byte_r[k_r[2:0]];
            4'd8:    data_oe_n = ~par_r;
            4'd9:    data_oe_n = 1'b0;
            4'd10: begin
              if (!data_s) begin
                ack_n   = 1'b1;
                state_n = ST_WAIT_IDLE;
              end else begin
                nack_s = 1'b1;
              end
            end
            default: data_oe_n = 1'b0;
          endcase
        end else if (cnt_r == 32'(PKT_TO - 1)) begin
          fail_s = 1'b1;
        end else begin
          k_n = k_r;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_n = cnt_r + 32'd1;
        if (clk_s && data_s) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end else if (cnt_r == 32'(PKT_TO - 1)) begin
          fail_s = 1'b1;
        end else begin
          state_n = ST_WAIT_IDLE;
        end
      end
      default: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        state_n   = ST_IDLE;
      end
    endcase

`ifdef PS2_TX_RETRY_EN
    retry_s = (fail_s || nack_s) && (retry_r < RETRY_LIM);
`else
    retry_s = 1'b0;
`endif

    // Failed attempt: restart the same byte, or give up and report error
    if (retry_s) begin
      state_n   = ST_INHIBIT;
      cnt_n     = 32'd0;
      clk_oe_n  = 1'b1;
      data_oe_n = 1'b0;
      ack_n     = 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_n   = retry_r + 8'd1;
`endif
    end else if (fail_s || nack_s) begin
      err_n     = 1'b1;
      ack_n     = 1'b0;
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      if (fail_s) begin
        done_n  = 1'b1;
        state_n = ST_IDLE;
      end else begin
        state_n = ST_WAIT_IDLE;
      end
    end else begin
      err_n = err_n;
    end
  end

  // State and registered outputs; reset releases both lines at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 32'd0;
      k_r       <= 4'd0;
      byte_r    <= 8'd0;
      par_r     <= 1'b0;
      clk_oe_r  <= 1'b0;
      data_oe_r <= 1'b0;
      done_r    <= 1'b0;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_r   <= 8'd0;
`endif
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      k_r       <= k_n;
      byte_r    <= byte_n;
      par_r     <= par_n;
      clk_oe_r  <= clk_oe_n;
      data_oe_r <= data_oe_n;
      done_r    <= done_n;
      ack_r     <= ack_n;
      err_r     <= err_n;
`ifdef PS2_TX_RETRY_EN
      retry_r   <= retry_n;
`endif
    end
  end

  assign bus.tx_ready = (state_r == ST_IDLE);
  assign rx_inhibit   = (state_r != ST_IDLE);
  assign bus.done     = done_r;
  assign bus.ack_ok   = ack_r;
  assign bus.error    = err_r;
  assign ps2_clk_oe   = clk_oe_r;
  assign ps2_data_oe  = data_oe_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 keyboard model
// on open-drain lines. Timings are shortened through parameters.
module tb_ps2_host_tx;

  localparam int INH    = 40;
  localparam int STO    = 3000;
  localparam int PTO    = 1500;
  localparam int MR     = 2;
  localparam int H      = 15;              // device clock half period
  localparam int PERIOD = INH + STO + 1;   // one timed-out attempt
`ifdef PS2_TX_RETRY_EN
  localparam int EXP_ATTEMPTS = MR + 1;
`else
  localparam int EXP_ATTEMPTS = 1;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic rx_inhibit, ps2_clk_oe, ps2_data_oe;
  wire  ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  wire  ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx_if bus ();

  ps2_host_tx #(.CLK_HZ(50_000_000), .INHIBIT_CYC(INH), .START_TO(STO),
                .PKT_TO(PTO), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .rx_inhibit(rx_inhibit),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe));

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [9:0] r_bits;
  bit r_seen, r_ack, r_err, r_dev_tmo, r_ack_hold, r_err_hold;
  int r_busy_bad, r_extra_bad, r_starts, r_bad_starts;

  // Expected frame as the device sees it: data LSB first, odd parity, stop=1.
  function automatic logic [9:0] frame_bits(input logic [7:0] b);
    logic [9:0] f;
    f[7:0] = b;
    f[8]   = ($countones(b) % 2 == 0);
    f[9]   = 1'b1;
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit hold, input logic [7:0] hd);
    @(negedge clk);
    bus.tx_data = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    if (hold) bus.tx_data = hd;
    else      bus.tx_valid = 1'b0;
  endtask

  // Keyboard model: wait for request, clock 11 bits, ACK (pull data) or NACK.
  task automatic device_frame(input bit nack, input int rst_at,
                              output logic [9:0] bits, output bit start_ok, output bit tmo);
    int w;
    bits = '0; start_ok = 1'b0; tmo = 1'b0;
    w = 0;
    while (ps2_clk_in !== 1'b0 && w < 20000) begin @(negedge clk); w++; end
    if (w >= 20000) begin tmo = 1'b1; return; end
    w = 0;
    while (ps2_clk_in !== 1'b1 && w < 20000) begin @(negedge clk); w++; end
    if (w >= 20000) begin tmo = 1'b1; return; end
    start_ok = (ps2_data_in === 1'b0);
    repeat ($urandom_range(20, 120)) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && !nack) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      if (k == rst_at) begin repeat (8) @(negedge clk); return; end
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      @(negedge clk);
      if (k <= 10) bits[k-1] = ps2_data_in;
      repeat (H - 1) @(negedge clk);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    r_seen = 1'b0; r_ack = 1'b0; r_err = 1'b0; r_busy_bad = 0;
    for (int c = 0; c < budget; c++) begin
      if (bus.done === 1'b1) begin
        r_seen = 1'b1; r_ack = bus.ack_ok; r_err = bus.error;
        bus.tx_valid = 1'b0;
        break;
      end
      if (bus.tx_ready !== 1'b0 || rx_inhibit !== 1'b1) r_busy_bad++;
      @(negedge clk);
    end
  endtask

  // Stimulus only: one transfer with the device model, results in r_* vars.
  task automatic run_frame(input logic [7:0] b, input bit nack, input bit hold, input logic [7:0] hd);
    logic [9:0] bits;
    bit so, tmo;
    r_starts = 0; r_bad_starts = 0; r_dev_tmo = 1'b0;
    send_byte(b, hold, hd);
    fork
      begin
        for (int a = 0; a < (nack ? EXP_ATTEMPTS : 1); a++) begin
          device_frame(nack, 0, bits, so, tmo);
          if (tmo) r_dev_tmo = 1'b1;
          if (so) r_starts++; else r_bad_starts++;
          r_bits = bits;
        end
      end
      wait_done(30000);
    join
    r_extra_bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || rx_inhibit !== 1'b0)
        r_extra_bad++;
    end
    r_ack_hold = bus.ack_ok;
    r_err_hold = bus.error;
  endtask

  task automatic test_reset();
    bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.tx_ready, bus.done, bus.ack_ok, bus.error, rx_inhibit, ps2_clk_oe, ps2_data_oe} !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL reset_in: got %b want 1000000", {bus.tx_ready, bus.done, bus.ack_ok, bus.error, rx_inhibit, ps2_clk_oe, ps2_data_oe});
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.tx_ready, bus.done, bus.ack_ok, bus.error, rx_inhibit, ps2_clk_oe, ps2_data_oe} !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL reset_out: got %b want 1000000", {bus.tx_ready, bus.done, bus.ack_ok, bus.error, rx_inhibit, ps2_clk_oe, ps2_data_oe});
    end
  endtask

  task automatic test_send_ed();
    run_frame(8'hED, 1'b0, 1'b0, 8'h00);
    tests_run++;
    if (r_bits !== frame_bits(8'hED) || r_bits !== 10'b11_1110_1101) begin
      tests_failed++; $display("FAIL ed_bits: got %b want %b", r_bits, frame_bits(8'hED));
    end
    tests_run++;
    if ({r_seen, r_ack, r_err} !== 3'b110) begin
      tests_failed++; $display("FAIL ed_result: got seen/ack/err %b want 110", {r_seen, r_ack, r_err});
    end
    tests_run++;
    if (r_starts !== 1 || r_dev_tmo !== 1'b0) begin
      tests_failed++; $display("FAIL ed_start: got starts %0d tmo %0d want 1 0", r_starts, r_dev_tmo);
    end
    tests_run++;
    if (r_busy_bad !== 0 || r_extra_bad !== 0 || r_ack_hold !== 1'b1) begin
      tests_failed++; $display("FAIL ed_once: got busy_bad %0d extra_bad %0d ack_hold %0d want 0 0 1", r_busy_bad, r_extra_bad, r_ack_hold);
    end
  endtask

  // Inhibit window timing plus start timeout with a silent device.
  task automatic test_timeout();
    int done_c, line_bad;
    bit e_clk, e_dat, d_ack, d_err, d_clk, d_dat, d_rdy;
    done_c = -1; line_bad = 0;
    send_byte(8'hF4, 1'b0, 8'h00);
    for (int c = 0; c <= EXP_ATTEMPTS * PERIOD + 5; c++) begin
      if (bus.done === 1'b1) begin
        done_c = c;
        d_ack = bus.ack_ok; d_err = bus.error; d_rdy = bus.tx_ready;
        d_clk = ps2_clk_oe; d_dat = ps2_data_oe;
        break;
      end
      e_clk = (c % PERIOD) < INH;
      e_dat = ((c % PERIOD) >= INH - 1) && ((c % PERIOD) <= INH + STO);
      if (c >= EXP_ATTEMPTS * PERIOD) begin e_clk = 1'b0; e_dat = 1'b0; end
      if (ps2_clk_oe !== e_clk || ps2_data_oe !== e_dat) line_bad++;
      @(negedge clk);
    end
    tests_run++;
    if (line_bad !== 0) begin
      tests_failed++; $display("FAIL inhibit_lines: got %0d bad cycles want 0", line_bad);
    end
    tests_run++;
    if (done_c !== EXP_ATTEMPTS * PERIOD) begin
      tests_failed++; $display("FAIL timeout_cycle: got %0d want %0d", done_c, EXP_ATTEMPTS * PERIOD);
    end else begin
      tests_run++;
      if ({d_ack, d_err, d_clk, d_dat, d_rdy} !== 5'b01001) begin
        tests_failed++; $display("FAIL timeout_state: got ack/err/clk/dat/rdy %b want 01001", {d_ack, d_err, d_clk, d_dat, d_rdy});
      end
    end
  endtask

  task automatic test_nack();
    logic [7:0] b;
    b = 8'($urandom);
    run_frame(b, 1'b1, 1'b0, 8'h00);
    tests_run++;
    if ({r_seen, r_ack, r_err} !== 3'b101) begin
      tests_failed++; $display("FAIL nack_result: got seen/ack/err %b want 101", {r_seen, r_ack, r_err});
    end
    tests_run++;
    if (r_starts !== EXP_ATTEMPTS || r_dev_tmo !== 1'b0 || r_extra_bad !== 0) begin
      tests_failed++; $display("FAIL nack_attempts: got %0d tmo %0d extra %0d want %0d 0 0", r_starts, r_dev_tmo, r_extra_bad, EXP_ATTEMPTS);
    end
    tests_run++;
    if (r_bits !== frame_bits(b)) begin
      tests_failed++; $display("FAIL nack_bits: got %b want %b", r_bits, frame_bits(b));
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] bits;
    bit so, tmo;
    send_byte(8'hED, 1'b0, 8'h00);
    device_frame(1'b0, 5, bits, so, tmo);
    tests_run++;
    if (ps2_data_oe !== 1'b1 || rx_inhibit !== 1'b1) begin
      tests_failed++; $display("FAIL pre_reset: got data_oe %0d inhibit %0d want 1 1", ps2_data_oe, rx_inhibit);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({ps2_clk_oe, ps2_data_oe, bus.tx_ready} !== 3'b001) begin
      tests_failed++; $display("FAIL mid_reset: got clk/dat/rdy %b want 001", {ps2_clk_oe, ps2_data_oe, bus.tx_ready});
    end
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    run_frame(8'hFF, 1'b0, 1'b0, 8'h00);
    tests_run++;
    if (r_bits !== frame_bits(8'hFF) || {r_seen, r_ack, r_err} !== 3'b110) begin
      tests_failed++; $display("FAIL after_reset: got bits %b res %b want %b 110", r_bits, {r_seen, r_ack, r_err}, frame_bits(8'hFF));
    end
  endtask

  task automatic test_busy_ignore();
    run_frame(8'hF4, 1'b0, 1'b1, 8'h5A);
    tests_run++;
    if (r_bits !== frame_bits(8'hF4)) begin
      tests_failed++; $display("FAIL busy_bits: got %b want %b", r_bits, frame_bits(8'hF4));
    end
    tests_run++;
    if (r_busy_bad !== 0 || r_extra_bad !== 0 || r_seen !== 1'b1) begin
      tests_failed++; $display("FAIL busy_ready: got busy_bad %0d extra_bad %0d seen %0d want 0 0 1", r_busy_bad, r_extra_bad, r_seen);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit nack;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      nack = ($urandom_range(0, 3) == 0);
      run_frame(b, nack, 1'b0, 8'h00);
      tests_run++;
      if (r_bits !== frame_bits(b)) begin
        tests_failed++; $display("FAIL rand_bits[%0d]: got %b want %b", i, r_bits, frame_bits(b));
      end
      tests_run++;
      if ({r_seen, r_ack, r_err, r_ack_hold, r_err_hold} !== {1'b1, !nack, nack, !nack, nack}) begin
        tests_failed++; $display("FAIL rand_result[%0d]: got %b want %b", i, {r_seen, r_ack, r_err, r_ack_hold, r_err_hold}, {1'b1, !nack, nack, !nack, nack});
      end
    end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_timeout();
    test_nack();
    test_reset_midframe();
    test_busy_ignore();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
